// File: rtl/fmul_pkg.sv
// Shared types and helpers for the parametrised floating-point multiplier.
package fmul_pkg;

  // Operand classification after decode (denormals are treated as zero).
  typedef enum logic [1:0] {
    ZERO = 2'd0,
    NORM = 2'd1,
    INF  = 2'd2,
    NAN  = 2'd3
  } fclass_e;

  // Exception flags reported alongside each result.
  typedef struct packed {
    logic ovf;
    logic udf;
    logic inexact;
    logic invalid;
  } fflags_t;

  // Exponent bias for an EW-bit exponent field.
  function automatic int fbias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

  // Total width of a packed {s,e,m} word.
  function automatic int fwidth(input int ew, input int mw);
    return 1 + ew + mw;
  endfunction

  // Split point of the (MW+1)-bit significand: ceil((MW+1)/2).
  function automatic int fsplit(input int mw);
    return (mw + 2) / 2;
  endfunction

  // Canonical quiet NaN {0, all ones, 1<<(MW-1)}, right-aligned in 64 bits.
  function automatic logic [63:0] fqnan(input int ew, input int mw);
    logic [63:0] r;
    r = '0;
    r[mw-1] = 1'b1;
    for (int i = 0; i < ew; i++) begin
      r[mw+i] = 1'b1;
    end
    return r;
  endfunction

  // Classify an operand from its exponent/mantissa summary bits.
  function automatic fclass_e fclassify(input logic exp_zero, input logic exp_ones,
                                        input logic man_zero);
    fclass_e c;
    if (exp_zero)      c = ZERO;
    else if (exp_ones) c = man_zero ? INF : NAN;
    else               c = NORM;
    return c;
  endfunction

endpackage

// File: rtl/fmul_if.sv
// Operand/result bus of the multiplier: valid/ready on both sides plus tag.
interface fmul_if #(
  parameter int EW   = 8,
  parameter int MW   = 23,
  parameter int TAGW = 5
);
  localparam int W = 1 + EW + MW;

  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    x1;
  logic [W-1:0]    x2;
  logic            rnd;
  logic [TAGW-1:0] in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    y;
  logic [TAGW-1:0] out_tag;
  logic            ovf;
  logic            udf;
  logic            inexact;
  logic            invalid;

  // Issue side: drives operands, consumes results.
  modport master (
    output in_valid, x1, x2, rnd, in_tag, out_ready,
    input  in_ready, out_valid, y, out_tag, ovf, udf, inexact, invalid
  );

  // Multiplier side.
  modport slave (
    input  in_valid, x1, x2, rnd, in_tag, out_ready,
    output in_ready, out_valid, y, out_tag, ovf, udf, inexact, invalid
  );

endinterface

// File: rtl/fmul_mant.sv
// Unsigned (MW+1)x(MW+1) significand multiplier split into four partial
// products at bit ceil((MW+1)/2); the caller registers and sums them.
module fmul_mant
  import fmul_pkg::*;
#(
  parameter int MW = 23
) (
  input  logic [MW:0]                          a_i,
  input  logic [MW:0]                          b_i,
  output logic [2*(MW+1-fsplit(MW))-1:0]       pp_hh_o,
  output logic [MW:0]                          pp_hl_o,
  output logic [MW:0]                          pp_lh_o,
  output logic [2*fsplit(MW)-1:0]              pp_ll_o
);
  localparam int H  = fsplit(MW);
  localparam int HI = MW + 1 - H;

  logic [HI-1:0] a_hi, b_hi;
  logic [H-1:0]  a_lo, b_lo;

  assign a_hi = a_i[MW:H];
  assign a_lo = a_i[H-1:0];
  assign b_hi = b_i[MW:H];
  assign b_lo = b_i[H-1:0];

  // Operands are zero-extended to the product width so no bits are lost.
  assign pp_hh_o = {{HI{1'b0}}, a_hi} * {{HI{1'b0}}, b_hi};
  assign pp_hl_o = {{H{1'b0}}, a_hi}  * {{HI{1'b0}}, b_lo};
  assign pp_lh_o = {{HI{1'b0}}, a_lo} * {{H{1'b0}}, b_hi};
  assign pp_ll_o = {{H{1'b0}}, a_lo}  * {{H{1'b0}}, b_lo};

endmodule

// File: rtl/fmul_pipe.sv
// Three-stage pipelined floating-point multiplier with RNE/truncate rounding,
// special-value handling, exception flags and a whole-pipe stall.
module fmul_pipe
  import fmul_pkg::*;
#(
  parameter int EW   = 8,
  parameter int MW   = 23,
  parameter int TAGW = 5
) (
  input  logic   clk,
  input  logic   rst,
  fmul_if.slave  bus
);
  localparam int W  = fwidth(EW, MW);
  localparam int PW = 2 * MW + 2;
  localparam int H  = fsplit(MW);
  localparam int HI = MW + 1 - H;
  localparam int XW = EW + 2;
  localparam logic signed [XW-1:0] BIAS_S = XW'(fbias(EW));
  localparam logic signed [XW-1:0] EMAX_S = XW'((1 << EW) - 1);
  localparam logic [W-1:0]         QNAN   = W'(fqnan(EW, MW));

  // The whole pipe moves only when the output slot is free or being taken.
  logic adv;

  // ---------------- S1 decode ----------------
  logic [W-1:0]  x_op [2];
  logic [EW-1:0] e_op [2];
  logic [MW:0]   m_op [2];
  fclass_e       cls_d [2];

  assign x_op[0] = bus.x1;
  assign x_op[1] = bus.x2;

  for (genvar gi = 0; gi < 2; gi++) begin : g_op
    assign e_op[gi]  = x_op[gi][W-2 -: EW];
    assign m_op[gi]  = {1'b1, x_op[gi][MW-1:0]};
    assign cls_d[gi] = fclassify(e_op[gi] == '0, &e_op[gi], x_op[gi][MW-1:0] == '0);
  end

  logic [2*HI-1:0] pp_hh_d;
  logic [MW:0]     pp_hl_d, pp_lh_d;
  logic [2*H-1:0]  pp_ll_d;

  fmul_mant #(.MW(MW)) u_mant (
    .a_i     (m_op[0]),
    .b_i     (m_op[1]),
    .pp_hh_o (pp_hh_d),
    .pp_hl_o (pp_hl_d),
    .pp_lh_o (pp_lh_d),
    .pp_ll_o (pp_ll_d)
  );

  logic            v1_q, rnd1_q, sign1_q;
  logic [TAGW-1:0] tag1_q;
  logic [EW-1:0]   ea1_q, eb1_q;
  fclass_e         clsa1_q, clsb1_q;
  logic [2*HI-1:0] pp_hh1_q;
  logic [MW:0]     pp_hl1_q, pp_lh1_q;
  logic [2*H-1:0]  pp_ll1_q;

  // S1 register: operands' exponents, classes, partial products, rnd and tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q     <= 1'b0;
      rnd1_q   <= 1'b0;
      sign1_q  <= 1'b0;
      tag1_q   <= '0;
      ea1_q    <= '0;
      eb1_q    <= '0;
      clsa1_q  <= ZERO;
      clsb1_q  <= ZERO;
      pp_hh1_q <= '0;
      pp_hl1_q <= '0;
      pp_lh1_q <= '0;
      pp_ll1_q <= '0;
    end else if (adv) begin
      v1_q     <= bus.in_valid;
      rnd1_q   <= bus.rnd;
      sign1_q  <= bus.x1[W-1] ^ bus.x2[W-1];
      tag1_q   <= bus.in_tag;
      ea1_q    <= e_op[0];
      eb1_q    <= e_op[1];
      clsa1_q  <= cls_d[0];
      clsb1_q  <= cls_d[1];
      pp_hh1_q <= pp_hh_d;
      pp_hl1_q <= pp_hl_d;
      pp_lh1_q <= pp_lh_d;
      pp_ll1_q <= pp_ll_d;
    end
  end

  // ---------------- S2 sum and normalise ----------------
  logic [PW-1:0]      prod_d;
  logic               norm_d;
  logic [2*MW-1:0]    frac_d;
  logic [2:0]         grs_d;
  logic signed [XW-1:0] ye0_d;

  // hh and ll never overlap, so they concatenate; the cross terms sit at bit H.
  assign prod_d = {pp_hh1_q, pp_ll1_q}
                + ({{(PW-MW-1){1'b0}}, pp_hl1_q} << H)
                + ({{(PW-MW-1){1'b0}}, pp_lh1_q} << H);
  assign norm_d = prod_d[PW-1];
  assign frac_d = norm_d ? prod_d[2*MW:1] : prod_d[2*MW-1:0];
  // The bit shifted out by normalisation still counts toward sticky.
  assign grs_d  = {frac_d[MW-1], frac_d[MW-2], (|frac_d[MW-3:0]) | (norm_d & prod_d[0])};
  assign ye0_d  = $signed({2'b00, ea1_q}) + $signed({2'b00, eb1_q}) - BIAS_S
                + $signed({{(XW-1){1'b0}}, norm_d});

  logic                 v2_q, rnd2_q, sign2_q;
  logic [TAGW-1:0]      tag2_q;
  fclass_e              clsa2_q, clsb2_q;
  logic [MW-1:0]        mant2_q;
  logic [2:0]           grs2_q;
  logic signed [XW-1:0] ye0_2_q;

  // S2 register: normalised mantissa, guard/round/sticky, biased exponent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_q    <= 1'b0;
      rnd2_q  <= 1'b0;
      sign2_q <= 1'b0;
      tag2_q  <= '0;
      clsa2_q <= ZERO;
      clsb2_q <= ZERO;
      mant2_q <= '0;
      grs2_q  <= '0;
      ye0_2_q <= '0;
    end else if (adv) begin
      v2_q    <= v1_q;
      rnd2_q  <= rnd1_q;
      sign2_q <= sign1_q;
      tag2_q  <= tag1_q;
      clsa2_q <= clsa1_q;
      clsb2_q <= clsb1_q;
      mant2_q <= frac_d[2*MW-1:MW];
      grs2_q  <= grs_d;
      ye0_2_q <= ye0_d;
    end
  end

  // ---------------- S3 round, range check, specials ----------------
  logic                 inc_d;
  logic [MW:0]          mant_inc_d;
  logic signed [XW-1:0] ye_d;
  logic [W-1:0]         y_d;
  fflags_t              flags_d;
  logic                 any_nan, any_inf, any_zero;

  assign inc_d      = ~rnd2_q & grs2_q[2] & (grs2_q[1] | grs2_q[0] | mant2_q[0]);
  // On carry-out the low MW bits are already zero, so only the exponent moves.
  assign mant_inc_d = {1'b0, mant2_q} + {{MW{1'b0}}, inc_d};
  assign ye_d       = ye0_2_q + $signed({{(XW-1){1'b0}}, mant_inc_d[MW]});
  assign any_nan    = (clsa2_q == NAN) || (clsb2_q == NAN);
  assign any_inf    = (clsa2_q == INF) || (clsb2_q == INF);
  assign any_zero   = (clsa2_q == ZERO) || (clsb2_q == ZERO);

  // Result select: specials first, then overflow/underflow, then the rounded value.
  always_comb begin
    y_d     = '0;
    flags_d = '0;
    if (any_nan || (any_inf && any_zero)) begin
      y_d             = QNAN;
      flags_d.invalid = 1'b1;
    end else if (any_inf) begin
      y_d = {sign2_q, {EW{1'b1}}, {MW{1'b0}}};
    end else if (any_zero) begin
      y_d = {sign2_q, {(W-1){1'b0}}};
    end else if (ye_d >= EMAX_S) begin
      y_d             = {sign2_q, {EW{1'b1}}, {MW{1'b0}}};
      flags_d.ovf     = 1'b1;
      flags_d.inexact = 1'b1;
    end else if (ye_d[XW-1] || (ye_d == '0)) begin
      y_d             = {sign2_q, {(W-1){1'b0}}};
      flags_d.udf     = 1'b1;
      flags_d.inexact = 1'b1;
    end else begin
      y_d             = {sign2_q, ye_d[EW-1:0], mant_inc_d[MW-1:0]};
      flags_d.inexact = |grs2_q;
    end
  end

  logic            v3_q;
  logic [W-1:0]    y3_q;
  logic [TAGW-1:0] tag3_q;
  fflags_t         flags3_q;

  // Output register; bubbles leave the last result in place so y stays clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3_q     <= 1'b0;
      y3_q     <= '0;
      tag3_q   <= '0;
      flags3_q <= '0;
    end else if (adv) begin
      v3_q <= v2_q;
      if (v2_q) begin
        y3_q     <= y_d;
        tag3_q   <= tag2_q;
        flags3_q <= flags_d;
      end
    end
  end

  assign adv           = ~v3_q | bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = v3_q;
  assign bus.y         = y3_q;
  assign bus.out_tag   = tag3_q;
  assign bus.ovf       = flags3_q.ovf;
  assign bus.udf       = flags3_q.udf;
  assign bus.inexact   = flags3_q.inexact;
  assign bus.invalid   = flags3_q.invalid;

endmodule

// File: tb/tb_fmul_pipe.sv
// Directed-vector bench for fmul_pipe: an fp32 instance and an fp16 instance.
module tb_fmul_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  fmul_if #(.EW(8), .MW(23), .TAGW(5)) bus32 ();
  fmul_if #(.EW(5), .MW(10), .TAGW(5)) bus16 ();

  fmul_pipe #(.EW(8), .MW(23), .TAGW(5)) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32.slave)
  );

  fmul_pipe #(.EW(5), .MW(10), .TAGW(5)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16.slave)
  );

  task automatic drive_idle;
    bus32.in_valid = 1'b0; bus32.x1 = '0; bus32.x2 = '0; bus32.rnd = 1'b0;
    bus32.in_tag = '0; bus32.out_ready = 1'b1;
    bus16.in_valid = 1'b0; bus16.x1 = '0; bus16.x2 = '0; bus16.rnd = 1'b0;
    bus16.in_tag = '0; bus16.out_ready = 1'b1;
  endtask

  // Issue one fp32 op and wait (bounded) for its result.
  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic r,
                      input logic [4:0] t, output logic [31:0] yo,
                      output logic [4:0] to, output logic [3:0] fo, output int lat);
    int guard;
    @(negedge clk);
    bus32.x1 = a; bus32.x2 = b; bus32.rnd = r; bus32.in_tag = t;
    bus32.in_valid = 1'b1; bus32.out_ready = 1'b1;
    guard = 0;
    while (!bus32.in_ready && guard < 20) begin @(negedge clk); guard++; end
    @(posedge clk);
    @(negedge clk);
    bus32.in_valid = 1'b0;
    lat = 1;
    while (!bus32.out_valid && lat < 20) begin @(negedge clk); lat++; end
    yo = bus32.y; to = bus32.out_tag;
    fo = {bus32.ovf, bus32.udf, bus32.inexact, bus32.invalid};
    $display("op32 %h * %h rnd=%0d tag=%0d -> y=%h tag=%0d flags=%b lat=%0d",
             a, b, r, t, yo, to, fo, lat);
  endtask

  // Issue one fp16 op and wait (bounded) for its result.
  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic [4:0] t,
                      output logic [15:0] yo, output logic [3:0] fo, output int lat);
    int guard;
    @(negedge clk);
    bus16.x1 = a; bus16.x2 = b; bus16.rnd = 1'b0; bus16.in_tag = t;
    bus16.in_valid = 1'b1; bus16.out_ready = 1'b1;
    guard = 0;
    while (!bus16.in_ready && guard < 20) begin @(negedge clk); guard++; end
    @(posedge clk);
    @(negedge clk);
    bus16.in_valid = 1'b0;
    lat = 1;
    while (!bus16.out_valid && lat < 20) begin @(negedge clk); lat++; end
    yo = bus16.y;
    fo = {bus16.ovf, bus16.udf, bus16.inexact, bus16.invalid};
    $display("op16 %h * %h -> y=%h flags=%b lat=%0d", a, b, yo, fo, lat);
  endtask

  task automatic test_reset;
    drive_idle();
    rst = 1'b1;
    bus32.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus32.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", bus32.out_valid);
    else passed++;
    checks++;
    if (bus32.y !== 32'h0) $display("FAIL reset_y got=%h exp=00000000", bus32.y);
    else passed++;
    checks++;
    if (bus32.out_tag !== 5'd0) $display("FAIL reset_tag got=%0d exp=0", bus32.out_tag);
    else passed++;
    checks++;
    if ({bus32.ovf, bus32.udf, bus32.inexact, bus32.invalid} !== 4'b0000)
      $display("FAIL reset_flags got=%b exp=0000",
               {bus32.ovf, bus32.udf, bus32.inexact, bus32.invalid});
    else passed++;
    checks++;
    if (bus16.out_valid !== 1'b0) $display("FAIL reset_out_valid16 got=%b exp=0", bus16.out_valid);
    else passed++;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus32.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", bus32.in_ready);
    else passed++;
    $display("reset: checked idle outputs and in_ready after release");
    bus32.out_ready = 1'b1;
  endtask

  task automatic test_basic;
    logic [31:0] yo; logic [4:0] to; logic [3:0] fo; int lat;
    op32(32'h3FC00000, 32'h40000000, 1'b0, 5'd7, yo, to, fo, lat);
    checks++;
    if (yo !== 32'h40400000) $display("FAIL basic_y got=%h exp=40400000", yo); else passed++;
    checks++;
    if (to !== 5'd7) $display("FAIL basic_tag got=%0d exp=7", to); else passed++;
    checks++;
    if (fo !== 4'b0000) $display("FAIL basic_flags got=%b exp=0000", fo); else passed++;
    checks++;
    if (lat !== 3) $display("FAIL basic_latency got=%0d exp=3", lat); else passed++;
  endtask

  task automatic test_rounding;
    logic [31:0] va [5] = '{32'h3F800001, 32'h3F800001, 32'h3F800001, 32'h3F800001, 32'h3F800003};
    logic [31:0] vb [5] = '{32'h3F800001, 32'h3F800001, 32'h3FC00000, 32'h3FC00000, 32'h3FC00000};
    logic        vr [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] ey [5] = '{32'h3F800002, 32'h3F800002, 32'h3FC00002, 32'h3FC00001, 32'h3FC00004};
    logic [31:0] yo; logic [4:0] to; logic [3:0] fo; int lat;
    for (int i = 0; i < 5; i++) begin
      op32(va[i], vb[i], vr[i], 5'(i + 1), yo, to, fo, lat);
      checks++;
      if (yo !== ey[i]) $display("FAIL round_y[%0d] got=%h exp=%h", i, yo, ey[i]); else passed++;
      checks++;
      if (fo !== 4'b0010) $display("FAIL round_flags[%0d] got=%b exp=0010", i, fo); else passed++;
      checks++;
      if (to !== 5'(i + 1)) $display("FAIL round_tag[%0d] got=%0d exp=%0d", i, to, i + 1); else passed++;
    end
  endtask

  task automatic test_specials;
    logic [31:0] va [8] = '{32'h7F000000, 32'h00800000, 32'hFF800000, 32'hFF800000,
                            32'h80000000, 32'h7FC00001, 32'h00000123, 32'hC0000000};
    logic [31:0] vb [8] = '{32'h7F000000, 32'h00800000, 32'h00000000, 32'h40000000,
                            32'h3F800000, 32'h3F800000, 32'h40000000, 32'h3FC00000};
    logic [31:0] ey [8] = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 32'hFF800000,
                            32'h80000000, 32'h7FC00000, 32'h00000000, 32'hC0400000};
    logic [3:0]  ef [8] = '{4'b1010, 4'b0110, 4'b0001, 4'b0000,
                            4'b0000, 4'b0001, 4'b0000, 4'b0000};
    logic [31:0] yo; logic [4:0] to; logic [3:0] fo; int lat;
    for (int i = 0; i < 8; i++) begin
      op32(va[i], vb[i], 1'b0, 5'(16 + i), yo, to, fo, lat);
      checks++;
      if (yo !== ey[i]) $display("FAIL special_y[%0d] got=%h exp=%h", i, yo, ey[i]); else passed++;
      checks++;
      if (fo !== ef[i]) $display("FAIL special_flags[%0d] got=%b exp=%b", i, fo, ef[i]); else passed++;
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] b_op [6] = '{32'h3F800000, 32'h3FC00000, 32'h40400000,
                              32'h40800000, 32'hBF800000, 32'h3F000000};
    logic [31:0] exp_y [6] = '{32'h40000000, 32'h40400000, 32'h40C00000,
                               32'h41000000, 32'hC0000000, 32'h3F800000};
    logic [31:0] got_y [6];
    logic [4:0]  got_t [6];
    int          got;
    int          stall_cnt;
    bit          stall_done;
    logic [31:0] held_y;
    logic [4:0]  held_t;
    got = 0; stall_cnt = 0; stall_done = 1'b0; held_y = '0; held_t = '0;
    bus32.out_ready = 1'b1;
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          int guard;
          @(negedge clk); #1;
          bus32.in_valid = 1'b1; bus32.x1 = 32'h40000000; bus32.x2 = b_op[k];
          bus32.rnd = 1'b0; bus32.in_tag = 5'(10 + k);
          guard = 0;
          while (!bus32.in_ready && guard < 50) begin @(negedge clk); #1; guard++; end
          @(posedge clk);
        end
        @(negedge clk); #1;
        bus32.in_valid = 1'b0;
      end
      begin
        for (int cyc = 0; cyc < 100 && got < 6; cyc++) begin
          @(negedge clk);
          if (!stall_done && stall_cnt == 0 && bus32.out_valid) begin
            bus32.out_ready = 1'b0;
            stall_cnt = 5;
            held_y = bus32.y;
            held_t = bus32.out_tag;
          end else if (stall_cnt > 0) begin
            checks++;
            if (bus32.in_ready !== 1'b0) $display("FAIL stall_in_ready got=%b exp=0", bus32.in_ready);
            else passed++;
            checks++;
            if (bus32.y !== held_y) $display("FAIL stall_y_held got=%h exp=%h", bus32.y, held_y);
            else passed++;
            checks++;
            if (bus32.out_tag !== held_t) $display("FAIL stall_tag_held got=%0d exp=%0d", bus32.out_tag, held_t);
            else passed++;
            checks++;
            if (bus32.out_valid !== 1'b1) $display("FAIL stall_out_valid got=%b exp=1", bus32.out_valid);
            else passed++;
            stall_cnt--;
            if (stall_cnt == 0) begin
              bus32.out_ready = 1'b1;
              stall_done = 1'b1;
            end
          end
          if (bus32.out_valid && bus32.out_ready) begin
            got_y[got] = bus32.y;
            got_t[got] = bus32.out_tag;
            $display("b2b result %0d: y=%h tag=%0d", got, bus32.y, bus32.out_tag);
            got++;
          end
        end
      end
    join
    checks++;
    if (got !== 6) $display("FAIL b2b_count got=%0d exp=6", got); else passed++;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (got_y[k] !== exp_y[k]) $display("FAIL b2b_y[%0d] got=%h exp=%h", k, got_y[k], exp_y[k]);
      else passed++;
      checks++;
      if (got_t[k] !== 5'(10 + k)) $display("FAIL b2b_tag[%0d] got=%0d exp=%0d", k, got_t[k], 10 + k);
      else passed++;
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    logic [31:0] yo; logic [4:0] to; logic [3:0] fo; int lat;
    bus32.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus32.in_valid = 1'b1; bus32.x1 = 32'h3FC00000; bus32.x2 = 32'h40000000;
      bus32.rnd = 1'b0; bus32.in_tag = 5'(21 + k);
      @(posedge clk);
    end
    @(negedge clk);
    bus32.in_valid = 1'b0;
    bus32.out_ready = 1'b0;
    checks++;
    if (bus32.out_valid !== 1'b1) $display("FAIL mid_pre_valid got=%b exp=1", bus32.out_valid);
    else passed++;
    rst = 1'b1;
    #1;
    checks++;
    if (bus32.out_valid !== 1'b0) $display("FAIL mid_rst_valid got=%b exp=0", bus32.out_valid);
    else passed++;
    checks++;
    if (bus32.y !== 32'h0) $display("FAIL mid_rst_y got=%h exp=00000000", bus32.y);
    else passed++;
    checks++;
    if (bus32.out_tag !== 5'd0) $display("FAIL mid_rst_tag got=%0d exp=0", bus32.out_tag);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus32.in_ready !== 1'b1) $display("FAIL mid_in_ready got=%b exp=1", bus32.in_ready);
    else passed++;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus32.out_valid) seen++;
    end
    checks++;
    if (seen !== 0) $display("FAIL mid_ghost_outputs got=%0d exp=0", seen); else passed++;
    checks++;
    if (bus32.y !== 32'h0) $display("FAIL mid_idle_y got=%h exp=00000000", bus32.y); else passed++;
    $display("mid-reset: in-flight ops discarded, %0d ghost outputs", seen);
    op32(32'h3FC00000, 32'h40000000, 1'b0, 5'd3, yo, to, fo, lat);
    checks++;
    if (yo !== 32'h40400000) $display("FAIL mid_recover_y got=%h exp=40400000", yo); else passed++;
    checks++;
    if (to !== 5'd3) $display("FAIL mid_recover_tag got=%0d exp=3", to); else passed++;
  endtask

  task automatic test_fp16;
    logic [15:0] yo; logic [3:0] fo; int lat;
    op16(16'h3C00, 16'h4000, 5'd1, yo, fo, lat);
    checks++;
    if (yo !== 16'h4000) $display("FAIL fp16_y0 got=%h exp=4000", yo); else passed++;
    checks++;
    if (fo !== 4'b0000) $display("FAIL fp16_flags0 got=%b exp=0000", fo); else passed++;
    checks++;
    if (lat !== 3) $display("FAIL fp16_latency got=%0d exp=3", lat); else passed++;
    op16(16'h7BFF, 16'h4000, 5'd2, yo, fo, lat);
    checks++;
    if (yo !== 16'h7C00) $display("FAIL fp16_y1 got=%h exp=7C00", yo); else passed++;
    checks++;
    if (fo !== 4'b1010) $display("FAIL fp16_flags1 got=%b exp=1010", fo); else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_specials();
    test_back_to_back();
    test_reset_mid();
    test_fp16();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fmul_pipe.md
Name: fmul_pipe

Overview:
Parametrised, pipelined IEEE-754-style floating-point multiplier for the FPU datapath. It generalises the fixed fp32 truncating multiplier in three ways: configurable exponent and mantissa widths, round-to-nearest-even or truncate selected per operation, and a valid/ready handshake with full-pipeline stall. It also handles specials and reports exception flags, and carries a tag so the issue logic can match results to their destination register.

Parameters:
EW, 8, exponent width (BIAS = 2^(EW-1)-1)
MW, 23, stored mantissa width (hidden bit implicit)
TAGW, 5, width of the opaque tag carried alongside each operation

Ports:
clk  in  1  clock
rst  in  1  reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept this cycle
x1  in  1+EW+MW  operand A {s,e,m}
x2  in  1+EW+MW  operand B
rnd  in  1  0 = round-nearest-even, 1 = truncate
in_tag  in  TAGW  tag, returned unchanged
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
y  out  1+EW+MW  product
out_tag  out  TAGW  tag of y
ovf  out  1  overflow (result forced to ±inf)
udf  out  1  underflow (result flushed to ±0)
inexact  out  1  discarded bits non-zero
invalid  out  1  inf*0 or NaN operand

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset: every stage valid bit, out_valid, y, out_tag and all flags = 0. in_ready = 1 from the first cycle after rst deasserts.
- Reset mid-operation: all in-flight operations are discarded. Nothing is emitted afterwards for them.
- Three register stages, S1..S3. Latency is 3 cycles from the accept edge to out_valid when there is no stall. Throughput is 1 operation per cycle.
- Accept happens when in_valid & in_ready.
- Stall: adv = ~out_valid | out_ready; in_ready = adv.
- When adv = 0, every stage holds its data, valid bit and tag, and y and the flags stay stable.
- A bubble (invalid stage) never blocks the stage behind it only through adv. No per-stage bubble collapse is required.
- S1:
  - register the operands, rnd and tag.
  - classify each operand: zero (e = 0, including denormals, which are flushed to zero), inf (e = all ones, m = 0), NaN (e = all ones, m ≠ 0).
  - form partial products of {1,m1} x {1,m2}, split at bit ceil((MW+1)/2).
- S2:
  - sum the partial products into the exact 2MW+2-bit product P.
  - normalise: if the top bit of P is set, shift right by 1 and add 1 to the exponent.
  - ye0 = e1 + e2 - BIAS + norm, computed in EW+2-bit signed arithmetic.
  - extract guard, round and sticky bits.
- S3:
  - RNE: increment the mantissa when guard & (round | sticky | lsb).
  - A mantissa carry-out sets mantissa = 0 and adds 1 to the exponent.
  - Truncate mode never increments.
  - inexact = guard | round | sticky, reported in both modes.
- Overflow: final exponent ≥ 2^EW-1 gives y = {s, all ones, 0} and ovf = 1 (inexact = 1).
- Underflow: final exponent ≤ 0 gives y = {s, 0, 0} and udf = 1 (inexact = 1). No denormal output is produced.
- Specials, with sign s = s1^s2 unless stated:
  - NaN operand or inf*0: y = canonical qNaN {0, all ones, 1<<(MW-1)}, invalid = 1, other flags 0.
  - inf*finite-nonzero: ±inf, no flags.
  - zero*finite: ±0, no flags.
- Flags are valid only with out_valid and are held with y during a stall.

Decomposition:
- Package fmul_pkg holds:
  - bias and field-width functions of EW/MW.
  - operand class enum: ZERO, NORM, INF, NAN.
  - the canonical-NaN constant function.
  - a flag struct {ovf, udf, inexact, invalid}.
- Sub-module fmul_mant: unsigned (MW+1)x(MW+1) split multiplier producing the partial products registered in S1. It is reusable by a future fused multiply-add.

Test Plan:
- 0x3FC00000 * 0x40000000 (1.5 * 2.0), rnd = 0, tag = 7 -> y = 0x40400000, out_tag = 7, 3 cycles after accept, all flags 0.
- 0x3F800001 * 0x3F800001 -> rnd = 0: y = 0x3F800002, inexact = 1. rnd = 1: y = 0x3F800002, inexact = 1 (the 2^-46 term is discarded).
- 0x7F000000 * 0x7F000000 -> y = 0x7F800000, ovf = 1. Then 0x00800000 * 0x00800000 -> y = 0x00000000, udf = 1. Then 0xFF800000 * 0x00000000 -> y = 0x7FC00000, invalid = 1.
- Back-to-back stream of 6 operations with out_ready held 0 for 5 cycles after the first result -> in_ready = 0 throughout the stall, y is held, no loss or duplication, all 6 results emitted in order with correct tags.
- Assert rst while 3 operations are in flight -> out_valid = 0 immediately and stays 0 until new input, y = 0, in_ready = 1 after release.
- Parameter sweep EW = 5, MW = 10 (fp16): 0x3C00 * 0x4000 -> 0x4000, 0x7BFF * 0x4000 -> 0x7C00 with ovf = 1.
